instr_burst_server: RTL and testbench

Responder end of the syn/ack/last instruction-transfer handshake. The instruction fetch stage drives the syn request. This block answers from a small loadable instruction memory. Each burst returns BURST consecutive words, acking one word per cycle and flagging the final word with last. A sequential read pointer persists across bursts, so repeated bursts walk the program. A write port lets the testbench or loader fill the memory.

---
 rtl/instr_burst_server_if.sv | 51 +++++
 rtl/instr_burst_server.sv | 149 ++++++++++++++
 tb/tb_instr_burst_server.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_burst_server_if.sv
// rtl/instr_burst_server_if.sv - syn/ack/last instruction-transfer bus between fetch initiator and burst server
//
// Purpose: bundles the request/response handshake and the memory load port.
// Signals:
//   s_i_syn    initiator -> server  burst request, held until last seen
//   s_o_instr  server -> initiator  returned instruction word
//   s_o_ack    server -> initiator  word valid this cycle
//   s_o_last   server -> initiator  final word of the burst
//   s_o_busy   server -> initiator  server is in a burst (WAIT/SEND/HOLD)
//   s_i_we     loader -> server     memory write enable
//   s_i_waddr  loader -> server     memory write address
//   s_i_wdata  loader -> server     memory write data
//   s_o_bursts server -> initiator  completed-burst count (INSTR_BURST_SERVER_COUNT_EN only)
// Modports: master (initiator/loader side), slave (server side).

interface instr_burst_server_if #(
  parameter int IWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic              s_i_syn;
  logic [IWIDTH-1:0] s_o_instr;
  logic              s_o_ack;
  logic              s_o_last;
  logic              s_o_busy;
  logic              s_i_we;
  logic [AWIDTH-1:0] s_i_waddr;
  logic [IWIDTH-1:0] s_i_wdata;
`ifdef INSTR_BURST_SERVER_COUNT_EN
  logic [15:0]       s_o_bursts;

  modport master (
    output s_i_syn, s_i_we, s_i_waddr, s_i_wdata,
    input  s_o_instr, s_o_ack, s_o_last, s_o_busy, s_o_bursts
  );

  modport slave (
    input  s_i_syn, s_i_we, s_i_waddr, s_i_wdata,
    output s_o_instr, s_o_ack, s_o_last, s_o_busy, s_o_bursts
  );
`else
  modport master (
    output s_i_syn, s_i_we, s_i_waddr, s_i_wdata,
    input  s_o_instr, s_o_ack, s_o_last, s_o_busy
  );

  modport slave (
    input  s_i_syn, s_i_we, s_i_waddr, s_i_wdata,
    output s_o_instr, s_o_ack, s_o_last, s_o_busy
  );
`endif
endinterface

// File: rtl/instr_burst_server.sv
// rtl/instr_burst_server.sv - responder for syn/ack/last instruction bursts from a loadable memory
//
// Purpose: answers each syn request with BURST consecutive words read from a
// 2**AWIDTH-word memory, one per cycle, the first LATENCY cycles after syn is
// sampled. The read pointer persists across bursts and wraps at DEPTH.
// Ports:
//   s_clk  clock, rising edge
//   s_rst  synchronous active-low reset (memory contents are kept)
//   bus    instr_burst_server_if.slave (syn/instr/ack/last/busy, write port)
// Optional feature: define INSTR_BURST_SERVER_COUNT_EN to add bus.s_o_bursts,
// a saturating 16-bit count of bursts that completed with last.

module instr_burst_server #(
  parameter int IWIDTH  = 32,
  parameter int AWIDTH  = 4,
  parameter int BURST   = 1,
  parameter int LATENCY = 1
) (
  input  logic                 s_clk,
  input  logic                 s_rst,
  instr_burst_server_if.slave  bus
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int CW    = AWIDTH + 1;
  localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SEND, HOLD} state_t;

  logic [IWIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic              ack_d, last_d, load_d;

  logic [IWIDTH-1:0] instr_q;
  logic              ack_q, last_q, busy_q;

  // Write port is independent of the FSM; writes land in any state.
  always_ff @(posedge s_clk) begin
    if (bus.s_i_we) begin
      mem[bus.s_i_waddr] <= bus.s_i_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    wcnt_d  = wcnt_q;
    ptr_d   = ptr_q;
    ack_d   = 1'b0;
    last_d  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_i_syn) begin
          wcnt_d = '0;
          if (LATENCY == 1) begin
            state_d = SEND;
          end else begin
            state_d = WAIT;
            lat_d   = LW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.s_i_syn) begin
          state_d = IDLE;
        end else begin
          // Leaving on the decrement that reaches zero puts the first ack
          // exactly LATENCY edges after syn was first sampled.
          lat_d = lat_q - LW'(1);
          if (lat_q == LW'(1)) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (!bus.s_i_syn) begin
          state_d = IDLE;
        end else begin
          ack_d  = 1'b1;
          load_d = 1'b1;
          ptr_d  = ptr_q + AWIDTH'(1);
          wcnt_d = wcnt_q + CW'(1);
          if (wcnt_q == CW'(BURST - 1)) begin
            last_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Stay here until the initiator drops syn so the held level does
        // not start another burst right after last.
        if (!bus.s_i_syn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      instr_q <= '0;
      ack_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      busy_q  <= (state_q != IDLE);
      // Registered read: a same-cycle write to this address shows next time.
      if (load_d) begin
        instr_q <= mem[ptr_q];
      end
    end
  end

  assign bus.s_o_instr = instr_q;
  assign bus.s_o_ack   = ack_q;
  assign bus.s_o_last  = last_q;
  assign bus.s_o_busy  = busy_q;

`ifdef INSTR_BURST_SERVER_COUNT_EN
  logic [15:0] bursts_q;

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      bursts_q <= '0;
    end else if (last_d && (bursts_q != 16'hFFFF)) begin
      bursts_q <= bursts_q + 16'd1;
    end
  end

  assign bus.s_o_bursts = bursts_q;
`endif

endmodule

// File: tb/tb_instr_burst_server.sv
// tb/tb_instr_burst_server.sv - self-checking bench for instr_burst_server

module tb_instr_burst_server;

  localparam int LAT1   = 3;
  localparam int BURST1 = 4;
  localparam int DEPTH1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  instr_burst_server_if #(.IWIDTH(32), .AWIDTH(4)) b0 ();
  instr_burst_server_if #(.IWIDTH(32), .AWIDTH(2)) b1 ();

  instr_burst_server #(.IWIDTH(32), .AWIDTH(4), .BURST(1), .LATENCY(1)) dut0 (
    .s_clk (clk),
    .s_rst (rst),
    .bus   (b0.slave)
  );

  instr_burst_server #(.IWIDTH(32), .AWIDTH(2), .BURST(BURST1), .LATENCY(LAT1)) dut1 (
    .s_clk (clk),
    .s_rst (rst),
    .bus   (b1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of dut1: memory image, persistent pointer, burst count.
  logic [31:0] model_mem [DEPTH1];
  int          model_ptr    = 0;
  int          model_bursts = 0;

  typedef struct {
    logic        syn;
    logic        ack;
    logic        last;
    logic        busy;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write1(input int addr, input logic [31:0] data);
    b1.s_i_we    = 1'b1;
    b1.s_i_waddr = 2'(addr);
    b1.s_i_wdata = data;
    step();
    b1.s_i_we    = 1'b0;
    model_mem[addr] = data;
  endtask

  // One request on dut1 taking 'take' words (BURST1 = full burst, fewer = abort).
  // wr_first writes wd to the address being read in the same cycle as the first read.
  task automatic run_burst(input int take, input bit wr_first, input logic [31:0] wd);
    int  n;
    bit  seen;
    b1.s_i_syn = 1'b1;
    if (take == 0) begin
      step();
      step();
      b1.s_i_syn = 1'b0;
      step();
      chk("abort_wait_ack", {31'd0, b1.s_o_ack}, 32'd0);
      step();
      chk("abort_wait_ack2", {31'd0, b1.s_o_ack}, 32'd0);
      return;
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      if (wr_first && n == LAT1) begin
        b1.s_i_we    = 1'b1;
        b1.s_i_waddr = 2'(model_ptr);
        b1.s_i_wdata = wd;
      end
      step();
      n++;
      b1.s_i_we = 1'b0;
      if (b1.s_o_ack) seen = 1'b1;
    end
    chk("ack_latency", n, LAT1 + 1);
    if (!seen) begin
      b1.s_i_syn = 1'b0;
      step();
      return;
    end
    for (int i = 0; i < take; i++) begin
      if (i > 0) step();
      chk("word", b1.s_o_instr, model_mem[model_ptr]);
      chk("ack", {31'd0, b1.s_o_ack}, 32'd1);
      chk("last", {31'd0, b1.s_o_last}, (i == BURST1 - 1) ? 32'd1 : 32'd0);
      if (wr_first && i == 0) model_mem[model_ptr] = wd;
      model_ptr = (model_ptr + 1) % DEPTH1;
    end
    if (take == BURST1) begin
      model_bursts++;
      step();
      chk("hold_ack", {31'd0, b1.s_o_ack}, 32'd0);
      chk("hold_busy", {31'd0, b1.s_o_busy}, 32'd1);
      b1.s_i_syn = 1'b0;
      step();
    end else begin
      b1.s_i_syn = 1'b0;
      step();
      chk("abort_ack", {31'd0, b1.s_o_ack}, 32'd0);
      chk("abort_last", {31'd0, b1.s_o_last}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b0.s_i_syn = 1'b0; b0.s_i_we = 1'b0; b0.s_i_waddr = '0; b0.s_i_wdata = '0;
    b1.s_i_syn = 1'b0; b1.s_i_we = 1'b0; b1.s_i_waddr = '0; b1.s_i_wdata = '0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h11};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h22};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h33};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h44};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h44};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h44};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h44};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h44};

    step();
    step();
    rst = 1'b1;
    chk("rst_ack1", {31'd0, b1.s_o_ack}, 32'd0);
    chk("rst_last1", {31'd0, b1.s_o_last}, 32'd0);
    chk("rst_busy1", {31'd0, b1.s_o_busy}, 32'd0);
    chk("rst_instr1", b1.s_o_instr, 32'd0);
    chk("rst_ack0", {31'd0, b0.s_o_ack}, 32'd0);
    chk("rst_instr0", b0.s_o_instr, 32'd0);

    // Load both memories with 0x11..0x44 at addresses 0..3.
    for (int a = 0; a < 4; a++) begin
      b0.s_i_we = 1'b1; b0.s_i_waddr = 4'(a); b0.s_i_wdata = 32'h11 * (a + 1);
      write1(a, 32'h11 * (a + 1));
      b0.s_i_we = 1'b0;
    end

    // dut0: BURST=1, LATENCY=1 single-word bursts.
    b0.s_i_syn = 1'b1;
    step();
    chk("b0_ack_k", {31'd0, b0.s_o_ack}, 32'd0);
    step();
    chk("b0_ack_k1", {31'd0, b0.s_o_ack}, 32'd1);
    chk("b0_last_k1", {31'd0, b0.s_o_last}, 32'd1);
    chk("b0_instr_k1", b0.s_o_instr, 32'h11);
    step();
    chk("b0_hold_ack", {31'd0, b0.s_o_ack}, 32'd0);
    chk("b0_hold_instr", b0.s_o_instr, 32'h11);
    b0.s_i_syn = 1'b0;
    step();
    b0.s_i_syn = 1'b1;
    step();
    step();
    chk("b0_second_ack", {31'd0, b0.s_o_ack}, 32'd1);
    chk("b0_second_instr", b0.s_o_instr, 32'h22);
    b0.s_i_syn = 1'b0;
    step();

    // dut1: cycle-exact timing of one full burst, wrapping the pointer to 0.
    for (int i = 0; i < 11; i++) begin
      b1.s_i_syn = tbl[i].syn;
      step();
      chk($sformatf("tbl%0d_ack", i), {31'd0, b1.s_o_ack}, {31'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_last", i), {31'd0, b1.s_o_last}, {31'd0, tbl[i].last});
      chk($sformatf("tbl%0d_busy", i), {31'd0, b1.s_o_busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_instr", i), b1.s_o_instr, tbl[i].instr);
    end
    model_bursts = 1;

    // Abort after two words, next burst continues with the third word.
    run_burst(2, 1'b0, 32'h0);
    run_burst(BURST1, 1'b0, 32'h0);

    // Same-cycle write and read of one address: old data first, new after wrap.
    run_burst(BURST1, 1'b1, 32'hDEAD);
    run_burst(BURST1, 1'b0, 32'h0);

    // Random writes and random-length requests against the model.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) write1(int'($urandom_range(0, 3)), $urandom);
      run_burst(int'($urandom_range(0, BURST1)), 1'b0, 32'h0);
    end

`ifdef INSTR_BURST_SERVER_COUNT_EN
    chk("bursts_random", {16'd0, b1.s_o_bursts}, 32'(model_bursts));
`endif

    // Reset in the middle of SEND.
    b1.s_i_syn = 1'b1;
    n = 0;
    while (!b1.s_o_ack && n < 10) begin
      step();
      n++;
    end
    chk("pre_reset_ack", {31'd0, b1.s_o_ack}, 32'd1);
    rst = 1'b0;
    step();
    chk("midrst_ack", {31'd0, b1.s_o_ack}, 32'd0);
    chk("midrst_last", {31'd0, b1.s_o_last}, 32'd0);
    chk("midrst_busy", {31'd0, b1.s_o_busy}, 32'd0);
    chk("midrst_instr", b1.s_o_instr, 32'd0);
    rst = 1'b1;
    b1.s_i_syn = 1'b0;
    step();
    model_ptr    = 0;
    model_bursts = 0;

    // Three complete bursts and one aborted; the first proves ptr restarted at 0.
    run_burst(BURST1, 1'b0, 32'h0);
    run_burst(BURST1, 1'b0, 32'h0);
    run_burst(BURST1, 1'b0, 32'h0);
    run_burst(1, 1'b0, 32'h0);
`ifdef INSTR_BURST_SERVER_COUNT_EN
    chk("bursts_after_reset", {16'd0, b1.s_o_bursts}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
